// File: rtl/rf_write_buffer_pkg.sv
// Shared types and widths for the register-file write buffer.
package rf_write_buffer_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_write_buffer_if.sv
// Producer, RF write port, bypass lookups and occupancy of the write buffer.
interface rf_write_buffer_if #(parameter int DEPTH = 4);
  import rf_write_buffer_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_addr;
  logic [XLEN-1:0] in_data;
  logic            drain_en;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd3;
  logic            we;
  logic [AW-1:0]   q1_addr;
  logic            q1_hit;
  logic [XLEN-1:0] q1_data;
  logic [AW-1:0]   q2_addr;
  logic            q2_hit;
  logic [XLEN-1:0] q2_data;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_addr, in_data, drain_en, q1_addr, q2_addr,
    input  in_ready, a3, wd3, we, q1_hit, q1_data, q2_hit, q2_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, q1_addr, q2_addr,
    output in_ready, a3, wd3, we, q1_hit, q1_data, q2_hit, q2_data, count
  );
endinterface

// File: rtl/rf_wb_lookup.sv
// Newest-match bypass search: walks entries oldest-to-newest from head so the
// last valid match (nearest tail) wins.
module rf_wb_lookup
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  rf_wr_t [DEPTH-1:0]         ent,
  input  logic   [DEPTH-1:0]         vld,
  input  logic   [$clog2(DEPTH)-1:0] head,
  input  logic   [AW-1:0]            q_addr,
  output logic                       hit,
  output logic   [XLEN-1:0]          data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (vld[idx] && ent[idx].addr == q_addr && q_addr != REG_ZERO) begin
        hit  = 1'b1;
        data = ent[idx].data;
      end
    end
  end
endmodule

// File: rtl/rf_write_buffer.sv
// Circular write buffer in front of the RF write port, draining one entry per
// cycle, with two bypass lookups over still-pending writes.
module rf_write_buffer
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  rf_write_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rf_wr_t [DEPTH-1:0] mem_q, mem_d;
  logic   [DEPTH-1:0] valid_q, valid_d;
  logic   [PW-1:0]    head_q, head_d;
  logic   [PW-1:0]    tail_q, tail_d;
  logic   [CW-1:0]    count_q, count_d;

  logic push, pop, not_empty;

  assign not_empty    = (count_q != '0);
  assign bus.in_ready = (count_q != CW'(DEPTH));
  // Gated by reset so a reset cycle never issues a stale RF write.
  assign pop          = not_empty && bus.drain_en && !reset;
  assign push         = bus.in_valid && bus.in_ready && (bus.in_addr != REG_ZERO);

  assign bus.we    = pop;
  assign bus.a3    = not_empty ? mem_q[head_q].addr : '0;
  assign bus.wd3   = not_empty ? mem_q[head_q].data : '0;
  assign bus.count = count_q;

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // Push only when not full, so tail never aliases the retiring head.
    if (push) begin
      mem_d[tail_q].addr = bus.in_addr;
      mem_d[tail_q].data = bus.in_data;
      valid_d[tail_q]    = 1'b1;
      tail_d             = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  rf_wb_lookup #(.DEPTH(DEPTH)) u_lkp1 (
    .ent(mem_q), .vld(valid_q), .head(head_q),
    .q_addr(bus.q1_addr), .hit(bus.q1_hit), .data(bus.q1_data)
  );

  rf_wb_lookup #(.DEPTH(DEPTH)) u_lkp2 (
    .ent(mem_q), .vld(valid_q), .head(head_q),
    .q_addr(bus.q2_addr), .hit(bus.q2_hit), .data(bus.q2_data)
  );
endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed bench for rf_write_buffer with DEPTH=4.
module tb_rf_write_buffer;
  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rf_write_buffer_if #(.DEPTH(4)) bus ();

  rf_write_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [4:0] a, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.drain_en = 1'b0; bus.q1_addr = '0; bus.q2_addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_a3", 32'(bus.a3), 0);
    chk("rst_wd3", bus.wd3, 0);
    chk("rst_q1hit", 32'(bus.q1_hit), 0);
    chk("rst_q1data", bus.q1_data, 0);

    // single write with drain enabled: no flow-through, then one RF write
    bus.drain_en = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 5'd5; bus.in_data = 32'h11;
    #1;
    chk("nofl_we", 32'(bus.we), 0);
    tick();
    bus.in_valid = 1'b0;
    bus.q1_addr = 5'd5;
    #1;
    chk("x5_count", 32'(bus.count), 1);
    chk("x5_we", 32'(bus.we), 1);
    chk("x5_a3", 32'(bus.a3), 5);
    chk("x5_wd3", bus.wd3, 32'h11);
    chk("x5_q1hit", 32'(bus.q1_hit), 1);
    chk("x5_q1data", bus.q1_data, 32'h11);
    tick();
    chk("x5_drained", 32'(bus.count), 0);
    chk("x5_we_off", 32'(bus.we), 0);

    // fill to DEPTH with drain blocked
    bus.drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) offer(5'(i), 32'h100 + 32'(i));
    bus.q2_addr = 5'd3;
    #1;
    chk("full_ready", 32'(bus.in_ready), 0);
    chk("full_count", 32'(bus.count), 4);
    chk("full_q2hit", 32'(bus.q2_hit), 1);
    chk("full_q2data", bus.q2_data, 32'h103);
    bus.q1_addr = 5'd9;
    offer(5'd9, 32'h99);
    chk("full_rej_count", 32'(bus.count), 4);
    chk("full_rej_q1hit", 32'(bus.q1_hit), 0);

    // full + drain together: one retire, no accept
    bus.in_valid = 1'b1; bus.in_addr = 5'd10; bus.in_data = 32'hAA;
    bus.drain_en = 1'b1;
    bus.q2_addr = 5'd10;
    #1;
    chk("fd_ready", 32'(bus.in_ready), 0);
    chk("fd_we", 32'(bus.we), 1);
    chk("fd_a3", 32'(bus.a3), 1);
    chk("fd_wd3", bus.wd3, 32'h101);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("fd_count", 32'(bus.count), 3);
    chk("fd_head_a3", 32'(bus.a3), 2);
    chk("fd_q2miss", 32'(bus.q2_hit), 0);
    for (int i = 2; i <= 4; i++) begin
      chk("order_wd3", bus.wd3, 32'h100 + 32'(i));
      tick();
    end
    chk("fill_drained", 32'(bus.count), 0);

    // duplicate address: newest wins in bypass, oldest drains first
    bus.drain_en = 1'b0;
    bus.q1_addr = 5'd7;
    offer(5'd7, 32'hA);
    offer(5'd7, 32'hB);
    chk("dup_count", 32'(bus.count), 2);
    chk("dup_q1hit", 32'(bus.q1_hit), 1);
    chk("dup_q1data", bus.q1_data, 32'hB);
    bus.drain_en = 1'b1;
    #1;
    chk("dup_wd3_a", bus.wd3, 32'hA);
    tick();
    chk("dup_wd3_b", bus.wd3, 32'hB);
    chk("dup_retire_hit", 32'(bus.q1_hit), 1);
    chk("dup_retire_data", bus.q1_data, 32'hB);
    tick();
    chk("dup_count0", 32'(bus.count), 0);
    chk("dup_q1miss", 32'(bus.q1_hit), 0);

    // writes to x0 are accepted but dropped
    bus.q1_addr = 5'd0;
    bus.in_valid = 1'b1; bus.in_addr = 5'd0; bus.in_data = 32'hDEAD;
    #1;
    chk("x0_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("x0_count", 32'(bus.count), 0);
    chk("x0_we", 32'(bus.we), 0);
    chk("x0_q1hit", 32'(bus.q1_hit), 0);

    // reset with pending entries discards them without an RF write
    bus.drain_en = 1'b0;
    bus.q1_addr = 5'd12;
    offer(5'd11, 32'h111);
    offer(5'd12, 32'h222);
    offer(5'd13, 32'h333);
    chk("pre_rst_count", 32'(bus.count), 3);
    chk("pre_rst_q1hit", 32'(bus.q1_hit), 1);
    reset = 1'b1;
    bus.drain_en = 1'b1;
    #1;
    chk("rst_mid_we", 32'(bus.we), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_count", 32'(bus.count), 0);
    chk("post_rst_we", 32'(bus.we), 0);
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    chk("post_rst_q1hit", 32'(bus.q1_hit), 0);
    chk("post_rst_q1data", bus.q1_data, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
